// File: rtl/lsu_mem_ctrl_pkg.sv
// ============================================================================
// Module      : lsu_mem_ctrl_pkg
// Description : Shared constants for the MEM-stage load/store controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lsu_mem_ctrl_pkg;

    localparam int unsigned ARCH_DEFAULT = 32;

    localparam logic [6:0] IMM_LOAD = 7'b0000011;
    localparam logic [6:0] STORE    = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef logic [1:0] lsu_state_t;
    localparam lsu_state_t IDLE    = 2'd0;
    localparam lsu_state_t REQ     = 2'd1;
    localparam lsu_state_t WAIT_RD = 2'd2;

    function automatic logic is_ldst(input logic [6:0] op);
        return (op == IMM_LOAD) || (op == STORE);
    endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_mem_ctrl_lane_gen.sv
// ============================================================================
// Module      : lsu_mem_ctrl_lane_gen
// Description : Byte enables, lane-replicated store data and legality flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_mem_ctrl_lane_gen
    import lsu_mem_ctrl_pkg::*;
#(
    parameter int ARCH   = 32,
    parameter int NBYTES = ARCH / 8
) (
    input  logic [2:0]        func3_in,
    input  logic [1:0]        off_in,
    input  logic              is_store_in,
    input  logic [ARCH-1:0]   data_in,
    output logic [NBYTES-1:0] be_out,
    output logic [ARCH-1:0]   wdata_out,
    output logic              legal_out
);

    localparam logic [NBYTES-1:0] c_be_byte = {{(NBYTES-1){1'b0}}, 1'b1};
    localparam logic [NBYTES-1:0] c_be_half = {{(NBYTES-2){1'b0}}, 2'b11};

    always_comb begin
        be_out    = '0;
        wdata_out = data_in;
        legal_out = 1'b0;
        case (func3_in)
            F3_B, F3_BU: begin
                // Unsigned variants exist only for loads
                legal_out = (func3_in == F3_B) || !is_store_in;
                be_out    = c_be_byte << off_in;
                wdata_out = {NBYTES{data_in[7:0]}};
            end
            F3_H, F3_HU: begin
                legal_out = !off_in[0] && ((func3_in == F3_H) || !is_store_in);
                be_out    = c_be_half << off_in;
                wdata_out = {(NBYTES/2){data_in[15:0]}};
            end
            F3_W: begin
                legal_out = (off_in == 2'd0);
                be_out    = '1;
                wdata_out = data_in;
            end
            default: begin
                legal_out = 1'b0;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/lsu_mem_ctrl.sv
// ============================================================================
// Module      : lsu_mem_ctrl
// Description : MEM-stage load/store controller driving a req/gnt/rvalid port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_mem_ctrl
    import lsu_mem_ctrl_pkg::*;
#(
    parameter int ARCH   = 32,
    parameter int NBYTES = ARCH / 8
) (
    input  logic              clk_in,
    input  logic              rstn_in,
    input  logic              valid_in,
    output logic              ready_out,
    input  logic [6:0]        op_code_in,
    input  logic [2:0]        func3_in,
    input  logic [ARCH-1:0]   addr_in,
    input  logic [ARCH-1:0]   st_data_in,
    output logic              mem_req_out,
    output logic              mem_we_out,
    output logic [NBYTES-1:0] mem_be_out,
    output logic [ARCH-1:0]   mem_addr_out,
    output logic [ARCH-1:0]   mem_wdata_out,
    input  logic              mem_gnt_in,
    input  logic              mem_rvalid_in,
    input  logic [ARCH-1:0]   mem_rdata_in,
    output logic [ARCH-1:0]   ld_data_out,
    output logic              ld_valid_out,
    output logic              err_out,
    output logic              stall_out
);

    lsu_state_t        state_q, state_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [NBYTES-1:0] be_q, be_d;
    logic [ARCH-1:0]   addr_q, addr_d;
    logic [ARCH-1:0]   wdata_q, wdata_d;
    logic [1:0]        off_q, off_d;
    logic [ARCH-1:0]   ld_data_q, ld_data_d;
    logic              ld_valid_q, ld_valid_d;
    logic              err_q, err_d;

    logic              w_is_ldst;
    logic              w_is_store;
    logic              w_accept;
    logic [NBYTES-1:0] w_be;
    logic [ARCH-1:0]   w_wdata;
    logic              w_legal;

    assign w_is_ldst  = is_ldst(op_code_in);
    assign w_is_store = (op_code_in == STORE);
    assign ready_out  = (state_q == IDLE);
    assign w_accept   = valid_in && ready_out && w_is_ldst;
    assign stall_out  = (valid_in && w_is_ldst && !ready_out) || (state_q != IDLE);

    lsu_mem_ctrl_lane_gen #(
        .ARCH   (ARCH),
        .NBYTES (NBYTES)
    ) u_lane_gen (
        .func3_in    (func3_in),
        .off_in      (addr_in[1:0]),
        .is_store_in (w_is_store),
        .data_in     (st_data_in),
        .be_out      (w_be),
        .wdata_out   (w_wdata),
        .legal_out   (w_legal)
    );

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        we_d       = we_q;
        be_d       = be_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        off_d      = off_q;
        ld_data_d  = ld_data_q;
        ld_valid_d = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (w_accept) begin
                    if (w_legal) begin
                        state_d = REQ;
                        req_d   = 1'b1;
                        we_d    = w_is_store;
                        be_d    = w_be;
                        addr_d  = {addr_in[ARCH-1:2], 2'b00};
                        wdata_d = w_wdata;
                        off_d   = addr_in[1:0];
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            REQ: begin
                // Memory outputs stay frozen until the grant; rvalid here is ignored
                if (mem_gnt_in) begin
                    req_d   = 1'b0;
                    state_d = we_q ? IDLE : WAIT_RD;
                end
            end
            WAIT_RD: begin
                if (mem_rvalid_in) begin
                    ld_data_d  = mem_rdata_in >> {off_q, 3'b000};
                    ld_valid_d = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rstn_in) begin
        if (!rstn_in) begin
            state_q    <= IDLE;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            be_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            off_q      <= '0;
            ld_data_q  <= '0;
            ld_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            we_q       <= we_d;
            be_q       <= be_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            off_q      <= off_d;
            ld_data_q  <= ld_data_d;
            ld_valid_q <= ld_valid_d;
            err_q      <= err_d;
        end
    end

    assign mem_req_out   = req_q;
    assign mem_we_out    = we_q;
    assign mem_be_out    = be_q;
    assign mem_addr_out  = addr_q;
    assign mem_wdata_out = wdata_q;
    assign ld_data_out   = ld_data_q;
    assign ld_valid_out  = ld_valid_q;
    assign err_out       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_lsu_mem_ctrl.sv
// ============================================================================
// Module      : tb_lsu_mem_ctrl
// Description : Directed plus randomized checks of lsu_mem_ctrl against a model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lsu_mem_ctrl;

    localparam int         ARCH     = 32;
    localparam int         NBYTES   = ARCH / 8;
    localparam logic [6:0] OP_LOAD  = 7'h03;
    localparam logic [6:0] OP_STORE = 7'h23;
    localparam logic [6:0] OP_ALU   = 7'h33;

    logic              clk_in = 1'b0;
    logic              rstn_in;
    logic              valid_in;
    logic              ready_out;
    logic [6:0]        op_code_in;
    logic [2:0]        func3_in;
    logic [ARCH-1:0]   addr_in;
    logic [ARCH-1:0]   st_data_in;
    logic              mem_req_out;
    logic              mem_we_out;
    logic [NBYTES-1:0] mem_be_out;
    logic [ARCH-1:0]   mem_addr_out;
    logic [ARCH-1:0]   mem_wdata_out;
    logic              mem_gnt_in;
    logic              mem_rvalid_in;
    logic [ARCH-1:0]   mem_rdata_in;
    logic [ARCH-1:0]   ld_data_out;
    logic              ld_valid_out;
    logic              err_out;
    logic              stall_out;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] last_ld;

    lsu_mem_ctrl #(.ARCH(ARCH), .NBYTES(NBYTES)) dut (
        .clk_in        (clk_in),
        .rstn_in       (rstn_in),
        .valid_in      (valid_in),
        .ready_out     (ready_out),
        .op_code_in    (op_code_in),
        .func3_in      (func3_in),
        .addr_in       (addr_in),
        .st_data_in    (st_data_in),
        .mem_req_out   (mem_req_out),
        .mem_we_out    (mem_we_out),
        .mem_be_out    (mem_be_out),
        .mem_addr_out  (mem_addr_out),
        .mem_wdata_out (mem_wdata_out),
        .mem_gnt_in    (mem_gnt_in),
        .mem_rvalid_in (mem_rvalid_in),
        .mem_rdata_in  (mem_rdata_in),
        .ld_data_out   (ld_data_out),
        .ld_valid_out  (ld_valid_out),
        .err_out       (err_out),
        .stall_out     (stall_out)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not reach its end");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: access size in bytes, 0 for an unknown func3
    function automatic int size_bytes(input logic [2:0] f3);
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2:       return 4;
            default:    return 0;
        endcase
    endfunction

    function automatic bit model_legal(input bit st, input logic [2:0] f3, input int off);
        int n = size_bytes(f3);
        if (n == 0) return 0;
        if (st && f3[2]) return 0;
        return (off % n) == 0;
    endfunction

    function automatic logic [31:0] model_be(input logic [2:0] f3, input int off);
        int n = size_bytes(f3);
        int m = ((1 << n) - 1) << off;
        return 32'(m & 15);
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
        int n = size_bytes(f3);
        logic [31:0] w = '0;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % n) +: 8];
        return w;
    endfunction

    task automatic txn(input string tag, input logic [6:0] op, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] data,
                       input int gd, input int rd, input logic [31:0] rdata);
        bit          ldst = (op == OP_LOAD) || (op == OP_STORE);
        bit          st   = (op == OP_STORE);
        int          off  = int'(addr[1:0]);
        logic [31:0] e_addr, e_be, e_wd, e_ld;
        chk({tag, ":ready_at_issue"}, 32'(ready_out), 32'd1);
        valid_in   = 1'b1;
        op_code_in = op;
        func3_in   = f3;
        addr_in    = addr;
        st_data_in = data;
        @(negedge clk_in);
        valid_in   = 1'b0;
        op_code_in = 7'($urandom);
        func3_in   = 3'($urandom);
        addr_in    = $urandom;
        st_data_in = $urandom;
        chk({tag, ":ld_valid_quiet"}, 32'(ld_valid_out), 32'd0);
        if (!ldst) begin
            chk({tag, ":noop_err"}, 32'(err_out), 32'd0);
            chk({tag, ":noop_req"}, 32'(mem_req_out), 32'd0);
            chk({tag, ":noop_ready"}, 32'(ready_out), 32'd1);
            return;
        end
        if (!model_legal(st, f3, off)) begin
            chk({tag, ":err_pulse"}, 32'(err_out), 32'd1);
            chk({tag, ":err_noreq"}, 32'(mem_req_out), 32'd0);
            @(negedge clk_in);
            chk({tag, ":err_end"}, 32'(err_out), 32'd0);
            chk({tag, ":err_noreq2"}, 32'(mem_req_out), 32'd0);
            chk({tag, ":ld_hold"}, ld_data_out, last_ld);
            return;
        end
        e_addr = {addr[31:2], 2'b00};
        e_be   = model_be(f3, off);
        e_wd   = model_wdata(f3, data);
        e_ld   = rdata >> (8 * off);
        chk({tag, ":err_none"}, 32'(err_out), 32'd0);
        chk({tag, ":stall"}, 32'(stall_out), 32'd1);
        chk({tag, ":ready_busy"}, 32'(ready_out), 32'd0);
        chk({tag, ":we"}, 32'(mem_we_out), 32'(st));
        for (int c = 0; c <= gd; c++) begin
            chk({tag, ":req"}, 32'(mem_req_out), 32'd1);
            chk({tag, ":addr"}, mem_addr_out, e_addr);
            chk({tag, ":be"}, 32'(mem_be_out), e_be);
            chk({tag, ":wdata"}, mem_wdata_out, e_wd);
            if (c < gd) begin
                mem_rvalid_in = 1'b1;
                mem_rdata_in  = $urandom;
                @(negedge clk_in);
            end
        end
        mem_rvalid_in = 1'b0;
        mem_gnt_in    = 1'b1;
        @(negedge clk_in);
        mem_gnt_in = 1'b0;
        chk({tag, ":req_drop"}, 32'(mem_req_out), 32'd0);
        if (st) begin
            chk({tag, ":ready_after_st"}, 32'(ready_out), 32'd1);
            chk({tag, ":ld_hold"}, ld_data_out, last_ld);
            return;
        end
        chk({tag, ":ready_wait"}, 32'(ready_out), 32'd0);
        for (int c = 1; c < rd; c++) begin
            @(negedge clk_in);
            chk({tag, ":ld_valid_early"}, 32'(ld_valid_out), 32'd0);
        end
        mem_rvalid_in = 1'b1;
        mem_rdata_in  = rdata;
        @(negedge clk_in);
        mem_rvalid_in = 1'b0;
        mem_rdata_in  = $urandom;
        chk({tag, ":ld_valid"}, 32'(ld_valid_out), 32'd1);
        chk({tag, ":ld_data"}, ld_data_out, e_ld);
        chk({tag, ":ready_after_ld"}, 32'(ready_out), 32'd1);
        last_ld = e_ld;
    endtask

    initial begin
        logic [31:0] lh_ext;
        rstn_in       = 1'b0;
        valid_in      = 1'b0;
        op_code_in    = '0;
        func3_in      = '0;
        addr_in       = '0;
        st_data_in    = '0;
        mem_gnt_in    = 1'b0;
        mem_rvalid_in = 1'b0;
        mem_rdata_in  = '0;
        last_ld       = '0;
        repeat (3) @(negedge clk_in);
        chk("rst:req", 32'(mem_req_out), 32'd0);
        chk("rst:we", 32'(mem_we_out), 32'd0);
        chk("rst:be", 32'(mem_be_out), 32'd0);
        chk("rst:addr", mem_addr_out, 32'd0);
        chk("rst:wdata", mem_wdata_out, 32'd0);
        chk("rst:ld_data", ld_data_out, 32'd0);
        chk("rst:ld_valid", 32'(ld_valid_out), 32'd0);
        chk("rst:err", 32'(err_out), 32'd0);
        chk("rst:ready", 32'(ready_out), 32'd1);
        chk("rst:stall", 32'(stall_out), 32'd0);
        rstn_in = 1'b1;
        @(negedge clk_in);

        txn("sw",   OP_STORE, 3'd2, 32'h100, 32'hDEADBEEF, 2, 1, 32'h0);
        txn("sb",   OP_STORE, 3'd0, 32'h203, 32'h000000A5, 1, 1, 32'h0);
        txn("lh",   OP_LOAD,  3'd1, 32'h302, 32'h0,        1, 3, 32'h80011234);
        lh_ext = {{16{ld_data_out[15]}}, ld_data_out[15:0]};
        chk("lh:sext_view", lh_ext, 32'hFFFF8001);
        txn("lw_mis", OP_LOAD,  3'd2, 32'h101, 32'h0, 0, 1, 32'h0);
        txn("lh_mis", OP_LOAD,  3'd1, 32'h103, 32'h0, 0, 1, 32'h0);
        txn("ld_f3",  OP_LOAD,  3'd3, 32'h100, 32'h0, 0, 1, 32'h0);
        txn("sbu_st", OP_STORE, 3'd4, 32'h100, 32'h0, 0, 1, 32'h0);
        txn("alu",    OP_ALU,   3'd2, 32'h100, 32'h0, 0, 1, 32'h0);
        txn("lbu_a",  OP_LOAD,  3'd4, 32'h11,  32'h0, 0, 1, 32'hCAFEF00D);
        txn("lbu_b",  OP_LOAD,  3'd4, 32'h14,  32'h0, 0, 1, 32'h123456F7);
        @(negedge clk_in);
        chk("b2b:single_pulse", 32'(ld_valid_out), 32'd0);

        // Reset while waiting for read data: the late rvalid must be dropped
        valid_in = 1'b1; op_code_in = OP_LOAD; func3_in = 3'd2; addr_in = 32'h200;
        @(negedge clk_in);
        valid_in   = 1'b0;
        mem_gnt_in = 1'b1;
        @(negedge clk_in);
        mem_gnt_in = 1'b0;
        chk("rst_wait:busy", 32'(ready_out), 32'd0);
        rstn_in = 1'b0;
        #1;
        chk("rst_wait:ready_async", 32'(ready_out), 32'd1);
        @(negedge clk_in);
        rstn_in       = 1'b1;
        mem_rvalid_in = 1'b1;
        mem_rdata_in  = 32'h55AA55AA;
        @(negedge clk_in);
        mem_rvalid_in = 1'b0;
        chk("rst_wait:no_ld_valid", 32'(ld_valid_out), 32'd0);
        chk("rst_wait:ready", 32'(ready_out), 32'd1);
        chk("rst_wait:ld_data", ld_data_out, 32'd0);
        last_ld = '0;

        // Reset during an ungranted request drops mem_req_out without a clock
        valid_in = 1'b1; op_code_in = OP_STORE; func3_in = 3'd2; addr_in = 32'h40;
        @(negedge clk_in);
        valid_in = 1'b0;
        chk("rst_req:req_up", 32'(mem_req_out), 32'd1);
        rstn_in = 1'b0;
        #1;
        chk("rst_req:req_drop", 32'(mem_req_out), 32'd0);
        @(negedge clk_in);
        rstn_in = 1'b1;
        @(negedge clk_in);

        for (int i = 0; i < 60; i++) begin
            int          r  = int'($urandom_range(0, 9));
            logic [6:0]  op = (r < 4) ? OP_LOAD : (r < 8) ? OP_STORE : OP_ALU;
            txn($sformatf("rnd%0d", i), op, 3'($urandom_range(0, 7)), $urandom, $urandom,
                int'($urandom_range(0, 3)), int'($urandom_range(1, 3)), $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
Load/store memory controller that sits directly upstream of load_data_ext in the MEM stage. It accepts one load/store request per transaction from the pipeline and drives a req/gnt/rvalid data-memory port with a word-aligned address, byte enables and lane-replicated store data. For loads it right-aligns the returned word by byte offset and presents it, with a valid pulse, to load_data_ext for sign/zero extension. It stalls the pipeline while a transaction is outstanding.

Parameters:
ARCH, 32, data/address width in bits (friscv_pkg value; 32 is the only verified value)
NBYTES, ARCH/8, byte-enable width

Ports:
clk_in  input  1  clock, rising edge
rstn_in  input  1  asynchronous active-low reset
valid_in  input  1  request present from MEM stage
ready_out  output  1  request accepted this cycle when valid_in=1
op_code_in  input  7  instruction opcode (IMM_LOAD or STORE)
func3_in  input  3  access size/sign
addr_in  input  ARCH  byte address
st_data_in  input  ARCH  store data, right-aligned
mem_req_out  output  1  memory request
mem_we_out  output  1  1 = write
mem_be_out  output  NBYTES  byte enables
mem_addr_out  output  ARCH  word-aligned address (bits [1:0]=0)
mem_wdata_out  output  ARCH  lane-replicated write data
mem_gnt_in  input  1  request granted
mem_rvalid_in  input  1  read data valid
mem_rdata_in  input  ARCH  read data word
ld_data_out  output  ARCH  right-aligned load word, feeds load_data_ext w_data_in
ld_valid_out  output  1  one-cycle pulse, ld_data_out valid
err_out  output  1  one-cycle pulse, misaligned or unsupported access
stall_out  output  1  pipeline stall

Behaviour:
- Reset: state IDLE; mem_req_out, mem_we_out, ld_valid_out, err_out = 0; mem_be_out, mem_addr_out, mem_wdata_out, ld_data_out = 0. All memory-port outputs are registered, so assertion of rstn_in drops mem_req_out immediately.
- FSM states: IDLE, REQ, WAIT_RD.
- ready_out = 1 only in IDLE. stall_out = valid_in & is_ldst & ~ready_out, OR a transaction is in progress (state != IDLE).
- Accept happens on the edge where valid_in & ready_out & opcode ∈ {IMM_LOAD, STORE}. Any other opcode is a no-op: no request, no error.
- Legality check at accept, using off = addr_in[1:0]:
  - byte (func3 0/4 load, 0 store): any off.
  - half (1/5 load, 1 store): off ∈ {0, 2}.
  - word (func3 2): off = 0.
  - Any other func3, or misalignment: err_out pulses the next cycle, no memory request, state stays IDLE.
- Legal accept: next cycle mem_req_out=1, mem_addr_out={addr[ARCH-1:2],2'b00}, mem_we_out=store. State → REQ.
  - mem_be_out: byte 0001<<off, half 0011<<off, word 1111.
  - mem_wdata_out: byte {4{d[7:0]}}, half {2{d[15:0]}}, word d.
- REQ: mem_req_out and all memory outputs held stable until mem_gnt_in.
  - On gnt edge: mem_req_out → 0.
  - Store → IDLE.
  - Load → WAIT_RD.
- WAIT_RD: on mem_rvalid_in, ld_data_out ← mem_rdata_in >> (8*off) with zero fill, ld_valid_out=1 for the next cycle, state → IDLE.
- Back-to-back: a new request can be accepted in the cycle ld_valid_out is high. Store-to-next latency is 2 cycles minimum, load-to-next is 3.
- Memory protocol: rvalid is at least one cycle after gnt; rvalid in IDLE or REQ is ignored. A stale rvalid after a mid-transaction reset is therefore dropped.
- Saved offset/func3 registers hold for the whole transaction; inputs may change after accept.
- ld_data_out holds its value between loads.
- No timeout; unlimited gnt/rvalid wait.

Decomposition:
- friscv_pkg gains: lsu_state_t enum (IDLE, REQ, WAIT_RD); STORE opcode constant beside IMM_LOAD; func3 size constants (F3_B=0, F3_H=1, F3_W=2, F3_BU=4, F3_HU=5).
- One natural sub-module: lsu_lane_gen (combinational), producing byte enables, replicated write data and the legality flag from func3/offset/data.

Test Plan:
- SW addr 0x100, data 0xDEADBEEF, gnt after 2 cycles -> mem_addr 0x100, be 1111, wdata 0xDEADBEEF held 3 cycles, mem_req drops after gnt, ready_out again 1 cycle after gnt.
- SB addr 0x203, data 0x000000A5 -> addr 0x200, be 1000, wdata 0xA5A5A5A5.
- LH addr 0x302, rdata 0x8001_1234, rvalid 3 cycles after gnt -> ld_data_out 0x00008001, ld_valid_out one-cycle pulse; downstream load_data_ext yields 0xFFFF8001.
- LW addr 0x101 -> err_out pulse next cycle, mem_req_out stays 0; LH addr 0x103 same; load with func3=3 same.
- Reset asserted in WAIT_RD, then rvalid arrives after release -> no ld_valid_out, state IDLE, ready_out 1.
- Two back-to-back LBU (0x10 off 1, 0x14 off 0), gnt same cycle as req -> second request issued in the cycle after first ld_valid_out; no lost or duplicated pulses.
